tdm_demux_16: RTL and testbench
===============================

// Module: tdm_demux_16
// PURPOSE
//  Time-division demultiplexer, the receive end of our 16:1 channel mux.
//  - Takes one serial bit per valid beat, framed by a slot-0 sync marker.
//  - Steers each slot into its own channel bit.
//  - Presents a complete, registered NCH-bit frame on dout.
//  - Sits between the serial link and the parallel channel consumers.
// PARAMETERS
//  NCH         16  data slots per frame (legal 2..32); slot k maps to dout[k]
//  HOLD_ON_ERR 1   1: errored frame leaves dout unchanged; 0: dout loads anyway
// PORTS
//  clk         in   1    single clock; all state updates on posedge
//  rst_n       in   1    asynchronous, active-low reset
//  din         in   1    serial data bit for the current slot
//  din_valid   in   1    beat qualifier; 0 = stall, no slot advance
//  frame_sync  in   1    high on the slot-0 beat only (qualified by din_valid)
//  dout        out  NCH  last completed frame, registered
//  frame_done  out  1    1-cycle pulse when dout has just loaded
//  locked      out  1    1 when FSM is in LOCKED
//  sync_err    out  1    1-cycle pulse on a framing violation
//  parity_err  out  1    1-cycle pulse on parity mismatch (tied 0 without macro)
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - dout=0, frame_done=0, locked=0, sync_err=0, parity_err=0.
//   - state=HUNT, slot=0, shadow register=0.
//   - A partial frame in progress is discarded.
//  General:
//   - Only beats with din_valid=1 are acted on. din_valid=0 holds every state
//     and deasserts all pulses.
//  HUNT:
//   - Beats without frame_sync are ignored.
//   - A beat with frame_sync=1 stores din as slot 0, sets slot=1, moves to LOCKED.
//  LOCKED:
//   - Each beat stores din into shadow[slot]; slot increments.
//   - Slot 0 beat with frame_sync=0: sync_err pulses, beat is discarded,
//     FSM returns to HUNT.
//   - Beat with frame_sync=1 at slot!=0: sync_err pulses and the partial frame
//     is dropped. That beat becomes slot 0 and slot=1 (immediate resync);
//     FSM stays in LOCKED.
//   - Final beat: on the edge that samples slot NCH-1 (NCH with macro),
//     dout <= {din, shadow[NCH-2:0]} (or the full shadow), frame_done=1 for
//     one cycle, slot=0. The next valid beat must carry frame_sync.
//  Latency and throughput:
//   - dout and frame_done are visible the cycle after the last-slot edge.
//   - Back-to-back frames run with no idle beat between them.
//  Counters:
//   - slot width is $clog2(NCH+1). It never exceeds the final slot and clears
//     on frame end or error.
//  Priority:
//   - reset > sync error > frame completion.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined:
//   - Frame is NCH+1 slots; slot NCH is an even-parity bit
//     (XOR of data slots ^ parity must be 0).
//   - Mismatch: parity_err pulses for one cycle.
//     HOLD_ON_ERR=1: dout held, no frame_done.
//     HOLD_ON_ERR=0: dout loads and frame_done pulses together with parity_err.
//   - frame_sync on the parity slot is a sync error.
//  TDM_DEMUX_PARITY_EN undefined:
//   - Frame is NCH slots; parity_err is constant 0.
// TESTING
//  1. rst_n low mid-stream -> all outputs 0 immediately, locked=0; stays in
//     HUNT until a sync beat.
//  2. Sync + 16 beats of 0111_0100_1110_1111 (slot0 first) -> dout=16'hF72E,
//     frame_done for 1 cycle, locked=1.
//  3. Same frame with din_valid toggled low every other cycle -> identical
//     dout=16'hF72E; frame_done only after the 16th valid beat.
//  4. frame_sync asserted at slot 7 -> sync_err pulse, old dout held; the new
//     frame from that beat completes normally 16 beats later.
//  5. No frame_sync on the slot-0 beat after a good frame -> sync_err, locked=0,
//     data ignored until the next sync.
//  6. Macro on, NCH=16, frame 16'h00FF with parity bit 1 -> parity_err, dout
//     unchanged (HOLD_ON_ERR=1); with parity bit 0 -> dout=16'h00FF.

Source files
------------

// File: rtl/tdm_demux_16.sv
// tdm_demux_16: receive end of the 16:1 TDM link; deserialises sync-framed slots into a registered frame.
// Define TDM_DEMUX_PARITY_EN to append an even-parity slot to every frame.
module tdm_demux_16 #(
    parameter int unsigned NCH         = 16,
    parameter int unsigned HOLD_ON_ERR = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [NCH-1:0] dout,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err,
    output logic           parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned LAST = NCH;
    localparam int unsigned SHW  = NCH;
`else
    localparam int unsigned LAST = NCH - 1;
    localparam int unsigned SHW  = NCH - 1;
`endif
    localparam int unsigned SW = $clog2(NCH + 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [SHW-1:0] shadow_q, shadow_d;
    logic [NCH-1:0] dout_q, dout_d;
    logic           frame_done_q, frame_done_d;
    logic           sync_err_q, sync_err_d;
    logic           parity_err_q, parity_err_d;
    logic [NCH-1:0] frame_data;
    logic           parity_ok;

    always_comb begin
`ifdef TDM_DEMUX_PARITY_EN
        frame_data = shadow_q;
        parity_ok  = ~(^shadow_q ^ din);
`else
        // Last data slot is taken straight from din, so the shadow holds NCH-1 bits.
        frame_data = {din, shadow_q};
        parity_ok  = 1'b1;
`endif
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        parity_err_d = 1'b0;

        if (din_valid) begin
            if (state_q == HUNT && !frame_sync) begin
                state_d = HUNT;
            end else if (state_q == LOCKED && slot_q == '0 && !frame_sync) begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
            end else if (frame_sync) begin
                // Any sync beat restarts the frame; mid-frame it also flags the violation.
                sync_err_d  = (state_q == LOCKED) && (slot_q != '0);
                shadow_d    = '0;
                shadow_d[0] = din;
                slot_d      = SW'(1);
                state_d     = LOCKED;
            end else if (slot_q == SW'(LAST)) begin
                slot_d       = '0;
                parity_err_d = !parity_ok;
                if (parity_ok || HOLD_ON_ERR == 0) begin
                    dout_d       = frame_data;
                    frame_done_d = 1'b1;
                end
            end else begin
                for (int unsigned i = 0; i < SHW; i++) begin
                    if (slot_q == SW'(i)) shadow_d[i] = din;
                end
                slot_d = slot_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign dout       = dout_q;
    assign frame_done = frame_done_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_16.sv
// Directed bench for tdm_demux_16; parity scenarios run only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_16;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NSLOT = 17;
`else
    localparam int NSLOT = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        frame_sync;
    logic [15:0] dout;
    logic        frame_done;
    logic        locked;
    logic        sync_err;
    logic        parity_err;

    int          n_total;
    int          n_pass;
    logic [15:0] exp_dout;

    tdm_demux_16 #(.NCH(16), .HOLD_ON_ERR(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic v, input logic s, input logic d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame slot0-first; gap inserts a stall beat before every valid beat.
    task automatic send_frame(input logic [15:0] data, input bit gap, input bit resync, input bit par_bad);
        logic [15:0] sh;
        logic        b;
        for (int k = 0; k < NSLOT; k++) begin
            if (gap) begin
                send(1'b0, 1'b0, 1'b1);
                chk("gap_frame_done", frame_done, 0);
                chk("gap_sync_err", sync_err, 0);
            end
            sh = data >> k;
            b  = (k < 16) ? sh[0] : (^data ^ par_bad);
            send(1'b1, k == 0, b);
            if (k == 0) begin
                chk("first_sync_err", sync_err, resync);
                chk("first_locked", locked, 1);
                chk("first_dout_held", dout, exp_dout);
            end
            if (k == NSLOT - 2) chk("pre_last_frame_done", frame_done, 0);
        end
        if (par_bad) begin
            chk("perr_flag", parity_err, 1);
            chk("perr_frame_done", frame_done, 0);
            chk("perr_dout_held", dout, exp_dout);
        end else begin
            exp_dout = data;
            chk("done_flag", frame_done, 1);
            chk("done_dout", dout, exp_dout);
            chk("done_parity_err", parity_err, 0);
            chk("done_locked", locked, 1);
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        exp_dout   = '0;
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        #3;
        chk("rst_dout", dout, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_parity_err", parity_err, 0);
        #9 rst_n = 1'b1;

        // Hunting: non-sync beats are ignored.
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 1'b0, 1'b1);
            chk("hunt_locked", locked, 0);
            chk("hunt_sync_err", sync_err, 0);
        end

        send_frame(16'hF72E, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        chk("idle_frame_done", frame_done, 0);
        chk("idle_dout", dout, 16'hF72E);

        // Back-to-back, then the reference frame again with stalls interleaved.
        send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        send_frame(16'hF72E, 1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        chk("gap_after_done", frame_done, 0);

        // Sync arriving at slot 7 restarts the frame.
        for (int k = 0; k < 7; k++) send(1'b1, k == 0, 1'b1);
        send_frame(16'hC3E1, 1'b0, 1'b1, 1'b0);

        // Missing sync on the slot-0 beat drops lock.
        send(1'b1, 1'b0, 1'b1);
        chk("nosync_sync_err", sync_err, 1);
        chk("nosync_locked", locked, 0);
        for (int k = 0; k < 20; k++) send(1'b1, 1'b0, k[0]);
        chk("nosync_pulse_clear", sync_err, 0);
        chk("nosync_still_hunt", locked, 0);
        chk("nosync_no_done", frame_done, 0);
        chk("nosync_dout_held", dout, 16'hC3E1);
        send_frame(16'h8001, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 5; k++) send(1'b1, k == 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_dout = '0;
        chk("midrst_dout", dout, 0);
        chk("midrst_locked", locked, 0);
        #2 rst_n = 1'b1;
        send(1'b1, 1'b0, 1'b1);
        chk("postrst_hunt", locked, 0);
        send_frame(16'h5A3C, 1'b0, 1'b0, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(16'h00FF, 1'b0, 1'b0, 1'b1);
        send_frame(16'h00FF, 1'b0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
